// File: rtl/chunked_lookahead_subtractor_pkg.sv
// ============================================================================
// Module   : lookahead_pkg
// Brief    : Shared types and elaboration helpers for the lookahead adder and
//            subtractor family.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lookahead_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    if (chunk < 1) return 1;
    return width / chunk;
  endfunction

  // True when the slice width divides the operand width cleanly.
  function automatic bit chunk_legal(input int width, input int chunk);
    if (chunk < 1 || chunk > width) return 1'b0;
    return (width % chunk) == 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chunked_lookahead_subtractor_if.sv
// ============================================================================
// Module   : chunked_lookahead_subtractor_if
// Brief    : Operand/result valid-ready bundle for the chunked subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chunked_lookahead_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_minuend;
  logic [WIDTH-1:0] i_subtrahend;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_diff;
  logic             o_borrow;

  modport slave (
    input  i_valid, i_minuend, i_subtrahend, i_ready,
    output o_ready, o_valid, o_diff, o_borrow
  );

  modport master (
    output i_valid, i_minuend, i_subtrahend, i_ready,
    input  o_ready, o_valid, o_diff, o_borrow
  );
endinterface

`default_nettype wire

// File: rtl/chunked_lookahead_subtractor_slice.sv
// ============================================================================
// Module   : borrow_lookahead_slice
// Brief    : Combinational CHUNK-bit subtract slice with full borrow lookahead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module borrow_lookahead_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK-1:0] gb;
  logic [CHUNK-1:0] pb;
  logic [CHUNK:0]   bw;

  assign gb    = ~a & b;
  assign pb    = ~(a ^ b);
  assign bw[0] = bin;

  // Each borrow is a flat sum of generate terms gated by the propagates above them.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic [i:0] term;
    for (genvar j = 0; j <= i; j++) begin : g_term
      if (j == i) begin : g_gen
        assign term[j] = gb[j];
      end else begin : g_prop
        assign term[j] = gb[j] & (&pb[i:j+1]);
      end
    end
    assign bw[i+1] = (|term) | (bin & (&pb[i:0]));
  end

  assign d    = a ^ b ^ bw[CHUNK-1:0];
  assign bout = bw[CHUNK];

endmodule

`default_nettype wire

// File: rtl/chunked_lookahead_subtractor.sv
// ============================================================================
// Module   : chunked_lookahead_subtractor
// Brief    : Sequential A-B, one CHUNK-bit lookahead slice per cycle, LSB first,
//            valid/ready on both sides. Optional macro SUB_SATURATE_EN floors
//            the result at zero when the final borrow is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunked_lookahead_subtractor
  import lookahead_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                           clk,
  input logic                           rst,
  chunked_lookahead_subtractor_if.slave bus
);

  localparam int NCHUNK   = nchunk(WIDTH, CHUNK);
  localparam bit CHUNK_OK = chunk_legal(WIDTH, CHUNK);
  localparam int IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (!CHUNK_OK) begin : g_bad_param
    $error("chunked_lookahead_subtractor: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_d;
  logic             slice_bout;

  assign slice_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign slice_b = b_q[int'(idx_q)*CHUNK +: CHUNK];

  borrow_lookahead_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .bin  (borrow_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d      = bus.i_minuend;
          b_d      = bus.i_subtrahend;
          borrow_d = 1'b0;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[int'(idx_q)*CHUNK +: CHUNK] = slice_d;
        borrow_d = slice_bout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
`ifdef SUB_SATURATE_EN
          if (slice_bout) begin
            diff_d = '0;
          end
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_diff   = diff_q;
  assign bus.o_borrow = borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_chunked_lookahead_subtractor.sv
// ============================================================================
// Module   : tb_chunked_lookahead_subtractor
// Brief    : Directed bench for the chunked subtractor, 16/4 and 16/16 builds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chunked_lookahead_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chunked_lookahead_subtractor_if #(.WIDTH(16)) bus1 ();
  chunked_lookahead_subtractor_if #(.WIDTH(16)) bus2 ();

  chunked_lookahead_subtractor #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  chunked_lookahead_subtractor #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

`ifdef SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        bo;
  } vec_t;

  vec_t vecs [9];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat_fix(input logic [15:0] d, input logic bo);
    return (SAT && bo) ? 16'h0000 : d;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_d, input logic exp_bo, input string name);
    int n;
    n = 0;
    while (!bus1.o_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_ready"}, 32'(bus1.o_ready), 32'd1);
    bus1.i_minuend    = a;
    bus1.i_subtrahend = b;
    bus1.i_valid      = 1'b1;
    @(posedge clk); #1;
    bus1.i_valid = 1'b0;
    n = 0;
    while (!bus1.o_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_latency"}, 32'(n), 32'd4);
    check({name, "_diff"}, 32'(bus1.o_diff), 32'(exp_d));
    check({name, "_borrow"}, 32'(bus1.o_borrow), 32'(exp_bo));
    bus1.i_ready = 1'b1;
    @(posedge clk); #1;
    bus1.i_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(bus1.o_valid), 32'd0);
  endtask

  initial begin
    int n;
    int nv;
    int first_c;
    int last_c;

    vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 16'h0000, 1'b0};
    vecs[3] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0};
    vecs[5] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0};
    vecs[6] = '{16'h0001, 16'h0002, 16'hFFFF, 1'b1};
    vecs[7] = '{16'hABCD, 16'h1111, 16'h9ABC, 1'b0};
    vecs[8] = '{16'h7FFF, 16'h8000, 16'hFFFF, 1'b1};

    rst = 1'b1;
    bus1.i_valid = 1'b0; bus1.i_ready = 1'b0;
    bus1.i_minuend = '0; bus1.i_subtrahend = '0;
    bus2.i_valid = 1'b0; bus2.i_ready = 1'b0;
    bus2.i_minuend = '0; bus2.i_subtrahend = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus1.o_valid), 32'd0);
    check("rst_ready", 32'(bus1.o_ready), 32'd1);
    check("rst_diff", 32'(bus1.o_diff), 32'd0);
    check("rst_borrow", 32'(bus1.o_borrow), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, sat_fix(vecs[i].d, vecs[i].bo), vecs[i].bo,
             $sformatf("vec%0d", i));
    end

    // Backpressure with competing operands offered during RUN and DONE.
    bus1.i_minuend = 16'h5A5A; bus1.i_subtrahend = 16'h1234; bus1.i_valid = 1'b1;
    @(posedge clk); #1;
    bus1.i_minuend = 16'hFFFF; bus1.i_subtrahend = 16'h0001;
    for (int c = 0; c < 3; c++) begin
      check("bp_run_ready", 32'(bus1.o_ready), 32'd0);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("bp_valid_rise", 32'(bus1.o_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(bus1.o_valid), 32'd1);
      check("bp_hold_diff", 32'(bus1.o_diff), 32'h4826);
      check("bp_hold_ready", 32'(bus1.o_ready), 32'd0);
    end
    check("bp_borrow", 32'(bus1.o_borrow), 32'd0);
    bus1.i_valid = 1'b0;
    bus1.i_ready = 1'b1;
    @(posedge clk); #1;
    bus1.i_ready = 1'b0;
    check("bp_release_valid", 32'(bus1.o_valid), 32'd0);
    check("bp_release_ready", 32'(bus1.o_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_not_queued", 32'(bus1.o_ready), 32'd1);

    // Asynchronous reset during the second RUN cycle.
    bus1.i_minuend = 16'h00FF; bus1.i_subtrahend = 16'h0001; bus1.i_valid = 1'b1;
    @(posedge clk); #1;
    bus1.i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus1.o_valid), 32'd0);
    check("midrst_ready", 32'(bus1.o_ready), 32'd1);
    check("midrst_diff", 32'(bus1.o_diff), 32'd0);
    check("midrst_borrow", 32'(bus1.o_borrow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(16'h00FF, 16'h000F, 16'h00F0, 1'b0, "after_rst");

    // Single-slice build: one RUN cycle.
    bus2.i_minuend = 16'hABCD; bus2.i_subtrahend = 16'h1111; bus2.i_valid = 1'b1;
    @(posedge clk); #1;
    bus2.i_valid = 1'b0;
    n = 0;
    while (!bus2.o_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("c16_latency", 32'(n), 32'd1);
    check("c16_diff", 32'(bus2.o_diff), 32'h9ABC);
    check("c16_borrow", 32'(bus2.o_borrow), 32'd0);
    bus2.i_ready = 1'b1;
    @(posedge clk); #1;
    bus2.i_ready = 1'b0;
    check("c16_valid_drop", 32'(bus2.o_valid), 32'd0);

    // Back-to-back on the single-slice build: a result every 3 cycles.
    bus2.i_minuend = 16'h0010; bus2.i_subtrahend = 16'h0001;
    bus2.i_valid = 1'b1; bus2.i_ready = 1'b1;
    nv = 0; first_c = 0; last_c = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus2.o_valid) begin
        if (nv == 0) first_c = c;
        last_c = c;
        nv++;
        check("b2b_diff", 32'(bus2.o_diff), 32'h000F);
      end
    end
    bus2.i_valid = 1'b0;
    check("b2b_count", 32'(nv), 32'd4);
    check("b2b_first", 32'(first_c), 32'd2);
    check("b2b_span", 32'(last_c - first_c), 32'd9);
    repeat (3) @(posedge clk);
    #1;
    bus2.i_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chunked_lookahead_subtractor.md
Name: chunked_lookahead_subtractor

Overview:
- Sequential unsigned subtractor computing i_minuend - i_subtrahend; the inverse-direction companion of the team's registered carry-lookahead adder.
- Processes the operands in CHUNK-bit slices, one slice per cycle, LSB slice first.
- Each slice uses borrow lookahead; the borrow is registered between slices.
- Valid/ready handshake on input and output, so it drops into the datapath between register stages.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands.
- i_minuend  input  WIDTH  A.
- i_subtrahend  input  WIDTH  B.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_diff  output  WIDTH  A-B modulo 2^WIDTH (saturated when feature enabled).
- o_borrow  output  1  borrow out of MSB; 1 means A<B.

Behaviour:
- NCHUNK = WIDTH/CHUNK.
- FSM states: IDLE, RUN, DONE.
- Reset (async, any state, including mid-RUN): state=IDLE; operand, diff, borrow and chunk-index registers cleared; o_valid=0, o_ready=1, o_diff=0, o_borrow=0; any in-flight operation is discarded.
- IDLE: o_ready=1. On i_valid&o_ready at edge k: latch A and B, set borrow register=0, idx=0, go to RUN.
- RUN: o_ready=0; inputs ignored. Each edge processes slice idx:
  - gb_i = ~a_i & b_i; pb_i = ~(a_i ^ b_i).
  - b_{i+1} = gb_i | (pb_i & b_i), with b_0 = the registered borrow.
  - d_i = a_i ^ b_i_in ^ borrow_i.
  - Write d into o_diff[idx*CHUNK +: CHUNK]; store the slice borrow-out; idx++.
  - After slice NCHUNK-1, go to DONE.
- DONE: o_valid=1, o_ready=0. o_diff and o_borrow are held stable until i_ready. On o_valid&i_ready go to IDLE; o_valid drops next cycle.
- Latency: o_valid rises exactly NCHUNK cycles after the accept edge. Throughput: one result per NCHUNK+2 cycles.
- o_diff and o_borrow are registered outputs. Partial results are visible during RUN but undefined for consumers; only the values while o_valid=1 count.
- NCHUNK=1: a single RUN cycle. WIDTH=CHUNK is legal.
- i_ready while not DONE has no effect. i_valid while not IDLE is ignored and not queued.
- Equal operands: o_diff=0, o_borrow=0. A=0, B=2^WIDTH-1: o_diff=1, o_borrow=1.

Optional Feature:
- Macro: SUB_SATURATE_EN.
- Defined: on entry to DONE, if the final borrow=1, o_diff is forced to 0 (unsigned floor saturation). o_borrow still reports 1. This costs one extra mux on the last RUN cycle and adds no latency.
- Undefined: o_diff is the modulo-2^WIDTH wrap result.

Decomposition:
- Shared package lookahead_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - an NCHUNK helper function;
  - the WIDTH%CHUNK legality check constant, reused by the adder family.
- Sub-module borrow_lookahead_slice: combinational CHUNK-bit unit with inputs a, b, bin and outputs d, bout. It is instantiated once and multiplexed by idx.

Test Plan:
- WIDTH=16, CHUNK=4: 0x1234-0x0234 -> o_valid 4 cycles after accept; o_diff=0x1000, o_borrow=0.
- 0x0000-0x0001 -> o_diff=0xFFFF, o_borrow=1. With SUB_SATURATE_EN: o_diff=0x0000, o_borrow=1.
- 0x8000-0x8000 -> o_diff=0x0000, o_borrow=0. 0x0000-0xFFFF -> o_diff=0x0001, o_borrow=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid stays 1 and o_diff stays constant. Assert i_valid during RUN and DONE with other operands -> ignored, o_ready=0.
- Reset asserted on the 2nd RUN cycle -> o_valid=0, o_ready=1, o_diff=0 immediately. A new op 0x00FF-0x000F afterwards -> 0x00F0.
- CHUNK=16 build: 0xABCD-0x1111 -> 0x9ABC, o_borrow=0, latency 1 cycle. Back-to-back ops with i_ready held high -> one result every NCHUNK+2 cycles.
